// File: rtl/xor8_lrc_ctrl_pkg.sv
// rtl/xor8_lrc_ctrl_pkg.sv - shared state encodings and default seed for the LRC controller
package xor8_lrc_ctrl_pkg;

  // Controller state encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Accumulator value loaded at packet start and on reset
  localparam logic [7:0] LRC_SEED_DEFAULT = 8'h00;

  // Byte-wise fold used by the datapath
  function automatic logic [7:0] lrc_fold(input logic [7:0] acc, input logic [7:0] din);
    return acc ^ din;
  endfunction

endpackage

// File: rtl/xor8_lrc_ctrl_xor8.sv
// rtl/xor8_lrc_ctrl_xor8.sv - shared 8-bit XOR datapath (F = A ^ B)
module xor8_lrc_ctrl_xor8
  import xor8_lrc_ctrl_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] f_o
);

  // Purely combinational fold of the stream byte into the accumulator
  always_comb begin
    f_o = lrc_fold(a_i, b_i);
  end

endmodule

// File: rtl/xor8_lrc_ctrl.sv
// rtl/xor8_lrc_ctrl.sv - LRC sequencer over a byte stream; optional check via XOR8_LRC_CHECK_EN
module xor8_lrc_ctrl
  import xor8_lrc_ctrl_pkg::*;
#(
  parameter int         LEN_W = 8,
  parameter logic [7:0] SEED  = LRC_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic [7:0]       lrc,
  output logic             lrc_valid,
`ifdef XOR8_LRC_CHECK_EN
  input  logic [7:0]       exp_lrc,
  output logic             lrc_err,
`endif
  input  logic             lrc_ack
);

  logic [1:0]       state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lrc_q, lrc_d;
  logic             lrc_valid_q, lrc_valid_d;
  logic [7:0]       xor_f;
  logic             xfer;

`ifdef XOR8_LRC_CHECK_EN
  logic [7:0]       exp_q, exp_d;
  logic             err_q, err_d;
`endif

  xor8_lrc_ctrl_xor8 u_xor8 (
    .a_i (acc_q),
    .b_i (din),
    .f_o (xor_f)
  );

  // Stream handshake is a pure function of state so ready never depends on valid
  always_comb begin
    din_ready = (state_q == ST_ACCUM);
    busy      = (state_q != ST_IDLE);
    xfer      = din_ready & din_valid;
  end

  // Next-state, counter, accumulator and result-register logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    lrc_d       = lrc_q;
    lrc_valid_d = lrc_valid_q;
`ifdef XOR8_LRC_CHECK_EN
    exp_d       = exp_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = SEED;
          cnt_d = len;
`ifdef XOR8_LRC_CHECK_EN
          exp_d = exp_lrc;
`endif
          if (len == '0) begin
            // Empty packet: result is the seed, published immediately
            state_d     = ST_DONE;
            lrc_d       = SEED;
            lrc_valid_d = 1'b1;
`ifdef XOR8_LRC_CHECK_EN
            err_d       = (SEED != exp_lrc);
`endif
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (xfer) begin
          acc_d = xor_f;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            // Last byte: register the folded value so lrc is stable in DONE
            state_d     = ST_DONE;
            lrc_d       = xor_f;
            lrc_valid_d = 1'b1;
`ifdef XOR8_LRC_CHECK_EN
            err_d       = (xor_f != exp_q);
`endif
          end
        end
      end
      ST_DONE: begin
        if (lrc_ack) begin
          state_d     = ST_IDLE;
          lrc_valid_d = 1'b0;
`ifdef XOR8_LRC_CHECK_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: begin
        state_d     = ST_IDLE;
        lrc_valid_d = 1'b0;
`ifdef XOR8_LRC_CHECK_EN
        err_d       = 1'b0;
`endif
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any packet in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= SEED;
      cnt_q       <= '0;
      lrc_q       <= SEED;
      lrc_valid_q <= 1'b0;
`ifdef XOR8_LRC_CHECK_EN
      exp_q       <= 8'h00;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      lrc_q       <= lrc_d;
      lrc_valid_q <= lrc_valid_d;
`ifdef XOR8_LRC_CHECK_EN
      exp_q       <= exp_d;
      err_q       <= err_d;
`endif
    end
  end

  // Registered result outputs
  always_comb begin
    lrc       = lrc_q;
    lrc_valid = lrc_valid_q;
`ifdef XOR8_LRC_CHECK_EN
    lrc_err   = err_q;
`endif
  end

endmodule

// File: tb/tb_xor8_lrc_ctrl.sv
// tb/tb_xor8_lrc_ctrl.sv - directed self-checking bench for xor8_lrc_ctrl
module tb_xor8_lrc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       busy;
  logic [7:0] lrc;
  logic       lrc_valid;
  logic       lrc_ack;
`ifdef XOR8_LRC_CHECK_EN
  logic [7:0] exp_lrc;
  logic       lrc_err;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  xor8_lrc_ctrl #(.LEN_W(8), .SEED(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .lrc       (lrc),
    .lrc_valid (lrc_valid),
`ifdef XOR8_LRC_CHECK_EN
    .exp_lrc   (exp_lrc),
    .lrc_err   (lrc_err),
`endif
    .lrc_ack   (lrc_ack)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag, input logic [7:0] exp_lrc_val);
    chk({tag, "_ready"}, {7'd0, din_ready}, 8'h00);
    chk({tag, "_busy"},  {7'd0, busy},      8'h00);
    chk({tag, "_valid"}, {7'd0, lrc_valid}, 8'h00);
    chk({tag, "_lrc"},   lrc,               exp_lrc_val);
  endtask

  // Start a packet from IDLE
  task automatic begin_pkt(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic ack_result();
    lrc_ack = 1'b1;
    tick();
    lrc_ack = 1'b0;
  endtask

  logic [7:0] t2_bytes [4];
  int         t2_gaps  [4];

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    din       = 8'h00;
    din_valid = 1'b0;
    lrc_ack   = 1'b0;
`ifdef XOR8_LRC_CHECK_EN
    exp_lrc   = 8'h00;
`endif
    t2_bytes = '{8'hFF, 8'h0F, 8'hF0, 8'hAA};
    t2_gaps  = '{1, 2, 3, 1};

    // Reset state
    tick();
    tick();
    chk_idle_reset("rst", 8'h00);
    rst_n = 1'b1;
    tick();
    chk_idle_reset("idle", 8'h00);

    // Test 1: basic len=3, 12^34^56 = 70
    begin_pkt(8'd3);
    chk("t1_ready_accum", {7'd0, din_ready}, 8'h01);
    chk("t1_busy_accum",  {7'd0, busy},      8'h01);
    send_byte(8'h12);
    din_valid = 1'b1;
    din       = 8'h34;
    tick();
    chk("t1_valid_early", {7'd0, lrc_valid}, 8'h00);
    din = 8'h56;
    tick();
    din_valid = 1'b0;
    chk("t1_valid", {7'd0, lrc_valid}, 8'h01);
    chk("t1_lrc",   lrc,               8'h70);
    chk("t1_ready_done", {7'd0, din_ready}, 8'h00);
    chk("t1_busy_done",  {7'd0, busy},      8'h01);
    ack_result();
    chk_idle_reset("t1_after_ack", 8'h70);

    // Test 2: stalls, FF^0F^F0^AA = AA
    begin_pkt(8'd4);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < t2_gaps[i]; g++) begin
        din = 8'h5C;
        tick();
        chk("t2_ready_gap", {7'd0, din_ready}, 8'h01);
        chk("t2_valid_gap", {7'd0, lrc_valid}, 8'h00);
      end
      send_byte(t2_bytes[i]);
    end
    chk("t2_valid", {7'd0, lrc_valid}, 8'h01);
    chk("t2_lrc",   lrc,               8'hAA);
    ack_result();
    chk_idle_reset("t2_after_ack", 8'hAA);

    // Test 3: zero length, din presented but never consumed
    din       = 8'hFF;
    din_valid = 1'b1;
    begin_pkt(8'd0);
    chk("t3_valid", {7'd0, lrc_valid}, 8'h01);
    chk("t3_lrc",   lrc,               8'h00);
    chk("t3_ready", {7'd0, din_ready}, 8'h00);
    din_valid = 1'b0;
    ack_result();
    chk_idle_reset("t3_after_ack", 8'h00);

    // Test 4: result back-pressure with start pulses ignored
    begin_pkt(8'd3);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    for (int c = 0; c < 10; c++) begin
      start     = c[0];
      len       = 8'd2;
      din_valid = 1'b1;
      din       = 8'h99;
      tick();
      chk("t4_hold_valid", {7'd0, lrc_valid}, 8'h01);
      chk("t4_hold_lrc",   lrc,               8'h70);
      chk("t4_hold_ready", {7'd0, din_ready}, 8'h00);
    end
    start     = 1'b1;
    lrc_ack   = 1'b1;
    din_valid = 1'b0;
    tick();
    start   = 1'b0;
    lrc_ack = 1'b0;
    chk_idle_reset("t4_ack_start", 8'h70);
    tick();
    chk_idle_reset("t4_still_idle", 8'h70);

    // Test 5: reset mid-packet, then len=1 byte 5A
    begin_pkt(8'd5);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("t5_busy_mid", {7'd0, busy}, 8'h01);
    rst_n = 1'b0;
    tick();
    chk_idle_reset("t5_reset", 8'h00);
    rst_n = 1'b1;
    begin_pkt(8'd1);
    send_byte(8'h5A);
    chk("t5_valid", {7'd0, lrc_valid}, 8'h01);
    chk("t5_lrc",   lrc,               8'h5A);
    ack_result();

`ifdef XOR8_LRC_CHECK_EN
    // Test 6: expected-LRC comparison
    exp_lrc = 8'h70;
    begin_pkt(8'd3);
    exp_lrc = 8'h00;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    chk("t6_err_match", {7'd0, lrc_err}, 8'h00);
    ack_result();
    exp_lrc = 8'h71;
    begin_pkt(8'd3);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    chk("t6_err_miss", {7'd0, lrc_err}, 8'h01);
    ack_result();
    chk("t6_err_clr", {7'd0, lrc_err}, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
